// File: rtl/uart_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_pkg - shared UART clocking constants and baud divisor helper. Rev 1.0
// ----------------------------------------------------------------------------
package uart_pkg;

  localparam int          DIV_W   = 16;
  localparam int          OVS     = 16;
  localparam int          DEF_DIV = 326;
  localparam int unsigned CLK_HZ  = 50_000_000;

  typedef logic [DIV_W-1:0] div_t;

  // Prescale divisor for a given baud rate at the package oversample ratio
  function automatic div_t baud_div(input int unsigned baud);
    return div_t'(CLK_HZ / (baud * OVS));
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_baud_gen_if - control/status bundle of the baud generator. Rev 1.0
// ----------------------------------------------------------------------------
interface uart_baud_gen_if #(
  parameter int DIV_W = uart_pkg::DIV_W
);

  logic             en;
  logic             restart;
  logic [DIV_W-1:0] div_i;
  logic             div_ld;
  logic [DIV_W-1:0] div_cur;
  logic             clkout;
  logic             tick_ovs;
  logic             tick_bit;
  logic             tick_mid;
  logic             ld_pend;

  modport master (
    output en, restart, div_i, div_ld,
    input  div_cur, clkout, tick_ovs, tick_bit, tick_mid, ld_pend
  );

  modport slave (
    input  en, restart, div_i, div_ld,
    output div_cur, clkout, tick_ovs, tick_bit, tick_mid, ld_pend
  );

endinterface
`default_nettype wire

// File: rtl/uart_prescale.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_prescale - run-time divisor prescaler with deferred divisor load. Rev 1.0
// ----------------------------------------------------------------------------
module uart_prescale #(
  parameter int DIV_W   = uart_pkg::DIV_W,
  parameter int DEF_DIV = uart_pkg::DEF_DIV
) (
  input  logic             clk50,
  input  logic             rst_n,
  input  logic             en,
  input  logic             restart,
  input  logic [DIV_W-1:0] div_i,
  input  logic             div_ld,
  output logic [DIV_W-1:0] div_cur,
  output logic             clkout,
  output logic             wrap,
  output logic             ld_pend
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);
  localparam logic [DIV_W-1:0] TWO = DIV_W'(2);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_cur_q, div_cur_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             ld_pend_q, ld_pend_d;
  logic             clkout_q, clkout_d;

  logic [DIV_W-1:0] div_clamped;
  logic [DIV_W-1:0] div_new;
  logic             apply_edge;

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      div_cur_q <= DIV_W'(DEF_DIV);
      pend_q    <= '0;
      ld_pend_q <= 1'b0;
      clkout_q  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_cur_q <= div_cur_d;
      pend_q    <= pend_d;
      ld_pend_q <= ld_pend_d;
      clkout_q  <= clkout_d;
    end
  end

  always_comb begin
    div_clamped = (div_i < TWO) ? TWO : div_i;
    wrap        = en && !restart && (cnt_q == div_cur_q - ONE);
    apply_edge  = wrap || !en || restart;
    div_new     = div_ld ? div_clamped : pend_q;

    // A fresh strobe on an apply edge bypasses pend and takes effect at once
    pend_d    = div_new;
    ld_pend_d = ld_pend_q | div_ld;
    div_cur_d = div_cur_q;
    if (apply_edge && (div_ld || ld_pend_q)) begin
      div_cur_d = div_new;
      ld_pend_d = 1'b0;
    end

    cnt_d    = cnt_q;
    clkout_d = clkout_q;
    if (restart) begin
      cnt_d    = '0;
      clkout_d = 1'b0;
    end else if (en) begin
      if (wrap) begin
        cnt_d    = '0;
        clkout_d = 1'b0;
      end else begin
        cnt_d = cnt_q + ONE;
        if (cnt_q == (div_cur_q >> 1) - ONE) clkout_d = 1'b1;
      end
    end else if (cnt_q >= div_cur_d) begin
      // Divisor shrank underneath a frozen count; restart the period
      cnt_d = '0;
    end
  end

  assign div_cur = div_cur_q;
  assign clkout  = clkout_q;
  assign ld_pend = ld_pend_q;

endmodule
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_baud_gen - oversample/bit/mid-bit tick generator for UART TX/RX. Rev 1.0
// ----------------------------------------------------------------------------
module uart_baud_gen #(
  parameter int DIV_W   = uart_pkg::DIV_W,
  parameter int DEF_DIV = uart_pkg::DEF_DIV,
  parameter int OVS     = uart_pkg::OVS
) (
  input  logic             clk50,
  input  logic             rst_n,
  uart_baud_gen_if.slave   bus
);

  localparam int              OVS_W    = $clog2(OVS);
  localparam logic [OVS_W-1:0] OVS_LAST = OVS_W'(OVS - 1);
  localparam logic [OVS_W-1:0] OVS_MID  = OVS_W'(OVS / 2 - 1);

  logic [OVS_W-1:0] ovs_cnt_q, ovs_cnt_d;
  logic             tick_ovs_q, tick_ovs_d;
  logic             tick_bit_q, tick_bit_d;
  logic             tick_mid_q, tick_mid_d;

  logic [DIV_W-1:0] div_cur;
  logic             clkout;
  logic             wrap;
  logic             ld_pend;

  uart_prescale #(
    .DIV_W   (DIV_W),
    .DEF_DIV (DEF_DIV)
  ) u_prescale (
    .clk50   (clk50),
    .rst_n   (rst_n),
    .en      (bus.en),
    .restart (bus.restart),
    .div_i   (bus.div_i),
    .div_ld  (bus.div_ld),
    .div_cur (div_cur),
    .clkout  (clkout),
    .wrap    (wrap),
    .ld_pend (ld_pend)
  );

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      ovs_cnt_q  <= '0;
      tick_ovs_q <= 1'b0;
      tick_bit_q <= 1'b0;
      tick_mid_q <= 1'b0;
    end else begin
      ovs_cnt_q  <= ovs_cnt_d;
      tick_ovs_q <= tick_ovs_d;
      tick_bit_q <= tick_bit_d;
      tick_mid_q <= tick_mid_d;
    end
  end

  // wrap is already masked by restart, so ticks drop on a restart edge
  always_comb begin
    ovs_cnt_d  = ovs_cnt_q;
    tick_ovs_d = wrap;
    tick_bit_d = wrap && (ovs_cnt_q == OVS_LAST);
    tick_mid_d = wrap && (ovs_cnt_q == OVS_MID);
    if (bus.restart) begin
      ovs_cnt_d = '0;
    end else if (wrap) begin
      ovs_cnt_d = (ovs_cnt_q == OVS_LAST) ? '0 : ovs_cnt_q + OVS_W'(1);
    end
  end

  assign bus.div_cur  = div_cur;
  assign bus.clkout   = clkout;
  assign bus.ld_pend  = ld_pend;
  assign bus.tick_ovs = tick_ovs_q;
  assign bus.tick_bit = tick_bit_q;
  assign bus.tick_mid = tick_mid_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_baud_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_uart_baud_gen - scoreboard bench: expected tick cycles queued up front. Rev 1.0
// ----------------------------------------------------------------------------
module tb_uart_baud_gen;
  import uart_pkg::*;

  localparam int D = DEF_DIV;

  logic clk50 = 1'b0;
  logic rst_n = 1'b0;
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  int   q_ovs[$];
  int   q_mid[$];
  int   q_bit[$];

  uart_baud_gen_if bus ();

  uart_baud_gen dut (
    .clk50 (clk50),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #10 clk50 = ~clk50;
  always @(posedge clk50) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk50);
  endtask

  // Scoreboard: every tick must land on a queued cycle, every queued cycle must see a tick
  always @(negedge clk50) begin
    if (mon_en) begin
      if (q_ovs.size() > 0 && q_ovs[0] == cyc) begin
        check("tick_ovs", bus.tick_ovs, 1);
        void'(q_ovs.pop_front());
      end else if (bus.tick_ovs) check("tick_ovs_spurious", bus.tick_ovs, 0);
      if (q_mid.size() > 0 && q_mid[0] == cyc) begin
        check("tick_mid", bus.tick_mid, 1);
        void'(q_mid.pop_front());
      end else if (bus.tick_mid) check("tick_mid_spurious", bus.tick_mid, 0);
      if (q_bit.size() > 0 && q_bit[0] == cyc) begin
        check("tick_bit", bus.tick_bit, 1);
        void'(q_bit.pop_front());
      end else if (bus.tick_bit) check("tick_bit_spurious", bus.tick_bit, 0);
    end
  end

  initial begin
    int   k, t, r, b, b2, e, f, hi, tg;
    logic prev;

    bus.en      = 1'b0;
    bus.restart = 1'b0;
    bus.div_ld  = 1'b0;
    bus.div_i   = '0;

    // Reset state
    wait_cyc(3);
    check("rst_div_cur",  bus.div_cur, D);
    check("rst_clkout",   bus.clkout, 0);
    check("rst_tick_ovs", bus.tick_ovs, 0);
    check("rst_tick_bit", bus.tick_bit, 0);
    check("rst_tick_mid", bus.tick_mid, 0);
    check("rst_ld_pend",  bus.ld_pend, 0);

    // Default divisor free run from reset release
    bus.en = 1'b1;
    rst_n  = 1'b1;
    k      = cyc;
    for (int n = 1; n <= 16; n++) q_ovs.push_back(k + D * n);
    q_mid.push_back(k + 8 * D);
    q_bit.push_back(k + 16 * D);
    mon_en = 1'b1;
    hi = 0;
    for (int i = 0; i < D; i++) begin
      wait_cyc(k + D + i);
      hi += int'(bus.clkout);
    end
    check("clkout_high_326", hi, D - (D >> 1));

    // Restart at cnt=200, ovs_cnt=9
    t = k + 16 * D;
    for (int n = 1; n <= 9; n++) q_ovs.push_back(t + D * n);
    q_mid.push_back(t + 8 * D);
    wait_cyc(t + 9 * D + 200);
    check("pre_restart_clkout", bus.clkout, 1);
    bus.restart = 1'b1;
    wait_cyc(t + 9 * D + 201);
    bus.restart = 1'b0;
    r = cyc;
    check("restart_clkout",   bus.clkout, 0);
    check("restart_tick_ovs", bus.tick_ovs, 0);
    for (int n = 1; n <= 16; n++) q_ovs.push_back(r + D * n);
    q_mid.push_back(r + 8 * D);
    q_bit.push_back(r + 16 * D);

    // Mid-period divisor load of 27 at cnt=100
    b = r + 16 * D;
    wait_cyc(b + 100);
    bus.div_i  = baud_div(115200);
    bus.div_ld = 1'b1;
    wait_cyc(b + 101);
    bus.div_ld = 1'b0;
    check("ld_pend_set",      bus.ld_pend, 1);
    check("div_cur_deferred", bus.div_cur, D);
    q_ovs.push_back(b + D);
    for (int n = 1; n <= 15; n++) q_ovs.push_back(b + D + 27 * n);
    q_mid.push_back(b + D + 7 * 27);
    q_bit.push_back(b + D + 15 * 27);
    wait_cyc(b + D - 1);
    check("ld_pend_held", bus.ld_pend, 1);
    wait_cyc(b + D);
    check("ld_pend_clear", bus.ld_pend, 0);
    check("div_cur_27",    bus.div_cur, 27);
    hi = 0;
    for (int i = 0; i < 27; i++) begin
      wait_cyc(b + D + i);
      hi += int'(bus.clkout);
    end
    check("clkout_high_27", hi, 14);

    // Loads while disabled apply immediately; shrink below cnt clears cnt
    b2 = b + D + 15 * 27;
    wait_cyc(b2 + 5);
    bus.en     = 1'b0;
    bus.div_i  = 16'd1;
    bus.div_ld = 1'b1;
    wait_cyc(b2 + 6);
    check("en0_load_clamp1", bus.div_cur, 2);
    bus.div_i = 16'(D);
    wait_cyc(b2 + 7);
    check("en0_load_326",    bus.div_cur, D);
    check("en0_ld_pend",     bus.ld_pend, 0);
    bus.div_ld = 1'b0;
    bus.en     = 1'b1;
    e = b2 + 8 + (D - 1);
    q_ovs.push_back(e);

    // Pause 50 cycles at cnt=150
    wait_cyc(e + 150);
    bus.en = 1'b0;
    wait_cyc(e + 151);
    prev = bus.clkout;
    tg   = 0;
    for (int i = 1; i < 50; i++) begin
      wait_cyc(e + 151 + i);
      if (bus.clkout !== prev) tg++;
    end
    bus.en = 1'b1;
    check("pause_clkout_frozen", tg, 0);
    q_ovs.push_back(e + 200 + (D - 150));

    // Restart with simultaneous load of 0 -> divisor 2
    f = e + 200 + (D - 150) + 10;
    wait_cyc(f);
    bus.restart = 1'b1;
    bus.div_i   = '0;
    bus.div_ld  = 1'b1;
    wait_cyc(f + 1);
    bus.restart = 1'b0;
    bus.div_ld  = 1'b0;
    check("restart_bypass_div", bus.div_cur, 2);
    check("restart_bypass_pend", bus.ld_pend, 0);
    check("div2_clkout_start",  bus.clkout, 0);
    for (int n = 1; n <= 25; n++) q_ovs.push_back(f + 1 + 2 * n);
    q_mid.push_back(f + 1 + 16);
    q_bit.push_back(f + 1 + 32);
    q_mid.push_back(f + 1 + 48);
    prev = bus.clkout;
    tg   = 0;
    for (int i = 1; i <= 7; i++) begin
      wait_cyc(f + 1 + i);
      if (bus.clkout !== prev) tg++;
      prev = bus.clkout;
    end
    check("div2_clkout_toggles", tg, 7);
    wait_cyc(f + 40);
    bus.div_i  = 16'd1;
    bus.div_ld = 1'b1;
    wait_cyc(f + 41);
    bus.div_ld = 1'b0;
    wait_cyc(f + 43);
    check("run_load_clamp1", bus.div_cur, 2);
    check("run_load_pend",   bus.ld_pend, 0);
    wait_cyc(f + 52);
    mon_en = 1'b0;
    check("q_ovs_drained", q_ovs.size(), 0);
    check("q_mid_drained", q_mid.size(), 0);
    check("q_bit_drained", q_bit.size(), 0);

    // Asynchronous reset between edges
    tg = 0;
    while (bus.clkout !== 1'b1 && tg < 4) begin
      @(negedge clk50);
      tg++;
    end
    check("pre_reset_clkout", bus.clkout, 1);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_clkout",  bus.clkout, 0);
    check("async_rst_div_cur", bus.div_cur, D);
    check("async_rst_tick",    bus.tick_ovs, 0);
    check("async_rst_ld_pend", bus.ld_pend, 0);
    @(negedge clk50);
    q_ovs.delete();
    q_mid.delete();
    q_bit.delete();
    rst_n = 1'b1;
    k     = cyc;
    q_ovs.push_back(k + D);
    q_ovs.push_back(k + 2 * D);
    mon_en = 1'b1;
    wait_cyc(k + 2 * D + 2);
    check("post_rst_div_cur", bus.div_cur, D);
    check("post_rst_q_ovs",   q_ovs.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
